// File: rtl/shifter_pipe_if.sv
// Bundle between the program sequencer/crossbar and the pipelined shifter.
//
// Handshake: there is no back-pressure and no ready. The sequencer
// issues one op per cycle by raising ps_shf_en with the operands for one
// cycle. A result is delivered when shf_ps_vld is high on a clock edge
// where ps_shf_hold is low; while hold is high, issue is ignored and every
// output, including vld, stays frozen.
interface shifter_pipe_if #(
    parameter int DATASIZE = 16
) ();
    logic                ps_shf_en;
    logic                ps_shf_hold;
    logic [2:0]          ps_shf_cls;
    logic                ps_shf_clr;
    logic [DATASIZE-1:0] xb_dtx;
    logic [DATASIZE-1:0] xb_dty;
    logic [DATASIZE-1:0] shf_xb_dt;
    logic                shf_ps_vld;
    logic                shf_ps_sv;
    logic                shf_ps_sz;
    logic                shf_ps_svs;

    // Sequencer side: drives issue/control, observes results.
    modport master (
        output ps_shf_en, ps_shf_hold, ps_shf_cls, ps_shf_clr, xb_dtx, xb_dty,
        input  shf_xb_dt, shf_ps_vld, shf_ps_sv, shf_ps_sz, shf_ps_svs
    );

    // Shifter side.
    modport slave (
        input  ps_shf_en, ps_shf_hold, ps_shf_cls, ps_shf_clr, xb_dtx, xb_dty,
        output shf_xb_dt, shf_ps_vld, shf_ps_sv, shf_ps_sz, shf_ps_svs
    );
endinterface

// File: rtl/shifter_pipe.sv
// Two-stage pipelined shifter: logical/arithmetic shift, rotate and
// leading zero/one count. Stage 1 captures the op, stage 2 computes and
// registers the result with per-result overflow/zero flags and a sticky
// overflow flag. A global hold freezes both stages.
module shifter_pipe #(
    parameter  int DATASIZE = 16,
    localparam int CNTW     = $clog2(DATASIZE) + 1
) (
    input  logic           clk,
    input  logic           rst,
    shifter_pipe_if.slave  bus
);
    localparam int W  = DATASIZE;
    localparam int LW = $clog2(DATASIZE);

    localparam logic [2:0] OP_LSHIFT = 3'b000;
    localparam logic [2:0] OP_ASHIFT = 3'b001;
    localparam logic [2:0] OP_ROT    = 3'b010;
    localparam logic [2:0] OP_LEFTZ  = 3'b011;
    localparam logic [2:0] OP_LEFTO  = 3'b100;

    // Width as a W+1 bit value so it compares directly against |s|.
    localparam logic [W:0]    W_M   = (W+1)'(W);
    localparam logic [CNTW-1:0] W_C = CNTW'(W);

    // Stage-1 registers.
    logic         s1_vld;
    logic [2:0]   s1_cls;
    logic [W-1:0] s1_x;
    logic [W-1:0] s1_y;

    // Combinational stage-2 datapath.
    logic           s_neg;
    logic [W:0]     y_ext;
    logic [W:0]     m;
    logic           big;
    logic [LW-1:0]  amt;
    logic [LW-1:0]  rot;
    logic [2*W-1:0] wide_l;
    logic [W-1:0]   lsh_l;
    logic           lsh_lost;
    logic [W-1:0]   lsh_r;
    logic [W-1:0]   ash_r;
    logic [W-1:0]   ash_back;
    logic [2*W-1:0] rl_wide;
    logic [2*W-1:0] rr_wide;
    logic [CNTW-1:0] lz;
    logic [CNTW-1:0] lo;
    logic [W-1:0]   res;
    logic           res_sv;
    logic           res_sz;
    logic           reserved;

    // Count of consecutive bits equal to b, starting at the MSB.
    function automatic logic [CNTW-1:0] lead_count(input logic [W-1:0] v, input logic b);
        logic [CNTW-1:0] cnt;
        logic            done;
        cnt  = '0;
        done = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!done && (v[i] == b)) begin
                cnt = cnt + CNTW'(1);
            end else begin
                done = 1'b1;
            end
        end
        return cnt;
    endfunction

    // Stage 1: capture the issued op unless the pipe is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_cls <= '0;
            s1_x   <= '0;
            s1_y   <= '0;
        end else if (!bus.ps_shf_hold) begin
            s1_vld <= bus.ps_shf_en;
            if (bus.ps_shf_en) begin
                s1_cls <= bus.ps_shf_cls;
                s1_x   <= bus.xb_dtx;
                s1_y   <= bus.xb_dty;
            end
        end
    end

    // Stage-2 datapath: magnitude of the signed amount, all op results, flags.
    always_comb begin
        s_neg    = s1_y[W-1];
        y_ext    = {s1_y[W-1], s1_y};
        // W+1 bits so the most negative amount still has a correct magnitude.
        m        = s_neg ? (~y_ext + (W+1)'(1)) : y_ext;
        big      = (m >= W_M);
        amt      = big ? '0 : m[LW-1:0];
        // W is a power of two, so the low bits are m mod W.
        rot      = m[LW-1:0];

        wide_l   = {{W{1'b0}}, s1_x} << amt;
        lsh_l    = wide_l[W-1:0];
        lsh_lost = |wide_l[2*W-1:W];
        lsh_r    = s1_x >> amt;
        ash_r    = $signed(s1_x) >>> amt;
        ash_back = $signed(lsh_l) >>> amt;

        rl_wide  = {s1_x, s1_x} << rot;
        rr_wide  = {s1_x, s1_x} >> rot;

        lz       = lead_count(s1_x, 1'b0);
        lo       = lead_count(s1_x, 1'b1);

        res      = '0;
        res_sv   = 1'b0;
        reserved = 1'b0;

        case (s1_cls)
            OP_LSHIFT: begin
                if (s_neg) begin
                    res = big ? '0 : lsh_r;
                end else begin
                    res    = big ? '0 : lsh_l;
                    res_sv = big ? (|s1_x) : lsh_lost;
                end
            end
            OP_ASHIFT: begin
                if (s_neg) begin
                    res = big ? {W{s1_x[W-1]}} : ash_r;
                end else begin
                    res    = big ? '0 : lsh_l;
                    res_sv = big ? (|s1_x) : (ash_back != s1_x);
                end
            end
            OP_ROT: begin
                res = s_neg ? rr_wide[W-1:0] : rl_wide[2*W-1:W];
            end
            OP_LEFTZ: begin
                res    = {{(W-CNTW){1'b0}}, lz};
                res_sv = (lz == W_C);
            end
            OP_LEFTO: begin
                res    = {{(W-CNTW){1'b0}}, lo};
                res_sv = (lo == W_C);
            end
            default: begin
                reserved = 1'b1;
            end
        endcase

        res_sz = (res == '0) && !reserved;
    end

    // Stage 2: register the result and flags; sticky overflow set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.shf_xb_dt  <= '0;
            bus.shf_ps_vld <= 1'b0;
            bus.shf_ps_sv  <= 1'b0;
            bus.shf_ps_sz  <= 1'b0;
            bus.shf_ps_svs <= 1'b0;
        end else if (!bus.ps_shf_hold) begin
            bus.shf_ps_vld <= s1_vld;
            // Outputs keep the last result while no new op arrives.
            if (s1_vld) begin
                bus.shf_xb_dt <= res;
                bus.shf_ps_sv <= res_sv;
                bus.shf_ps_sz <= res_sz;
            end
            if (s1_vld && res_sv) begin
                bus.shf_ps_svs <= 1'b1;
            end else if (bus.ps_shf_clr) begin
                bus.shf_ps_svs <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shifter_pipe.sv
// Directed testbench for shifter_pipe: a vector table streamed
// back-to-back through the pipe and checked by an in-order scoreboard,
// plus hand-written sequences for hold, async reset and the sticky flag.
module tb_shifter_pipe;
    localparam int W = 16;

    localparam logic [2:0] LSH = 3'b000;
    localparam logic [2:0] ASH = 3'b001;
    localparam logic [2:0] ROT = 3'b010;
    localparam logic [2:0] LZ  = 3'b011;
    localparam logic [2:0] LO  = 3'b100;

    typedef struct {
        logic [2:0]   cls;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] dt;
        logic         sv;
        logic         sz;
    } vec_t;

    localparam int NV = 28;

    logic clk;
    logic rst;

    shifter_pipe_if #(.DATASIZE(W)) vif ();

    shifter_pipe #(.DATASIZE(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int   n_vec = 0;
    int   n_err = 0;
    int   n_results = 0;
    logic last_hold = 1'b0;
    logic [W+1:0] exp_q[$];
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        vif.ps_shf_en  = 1'b1;
        vif.ps_shf_cls = c;
        vif.xb_dtx     = x;
        vif.xb_dty     = y;
    endtask

    task automatic issue(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] edt, input logic esv, input logic esz);
        drive_op(c, x, y);
        exp_q.push_back({edt, esv, esz});
    endtask

    task automatic idle();
        vif.ps_shf_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    // ---------------- scoreboard ----------------
    // Hold value seen by the DUT at the last edge: a vld with hold low is a new result.
    always @(posedge clk) last_hold <= vif.ps_shf_hold;

    // Pops one expectation per newly registered result and compares it.
    always @(negedge clk) begin
        if (!rst && !last_hold && vif.shf_ps_vld) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got dt %h expected no result", vif.shf_xb_dt);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                chk("sb_dt", 32'(vif.shf_xb_dt), 32'(e[W+1:2]));
                chk("sb_sv", 32'(vif.shf_ps_sv), 32'(e[1]));
                chk("sb_sz", 32'(vif.shf_ps_sz), 32'(e[0]));
                n_results++;
            end
        end
    end

    // ---------------- test ----------------
    initial begin
        int base;

        vecs[0]  = '{LSH, 16'h00F0, 16'h0004, 16'h0F00, 1'b0, 1'b0};
        vecs[1]  = '{LSH, 16'h00F0, 16'hFFFC, 16'h000F, 1'b0, 1'b0};
        vecs[2]  = '{LSH, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0};
        vecs[3]  = '{LSH, 16'h1234, 16'h0010, 16'h0000, 1'b1, 1'b1};
        vecs[4]  = '{LSH, 16'h1234, 16'hFFF0, 16'h0000, 1'b0, 1'b1};
        vecs[5]  = '{LSH, 16'h0000, 16'h0005, 16'h0000, 1'b0, 1'b1};
        vecs[6]  = '{LSH, 16'h00F0, 16'h000C, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{ASH, 16'hF000, 16'hFFFC, 16'hFF00, 1'b0, 1'b0};
        vecs[8]  = '{ASH, 16'h4000, 16'h0001, 16'h8000, 1'b1, 1'b0};
        vecs[9]  = '{ASH, 16'h0001, 16'h0010, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{ASH, 16'h8000, 16'h8000, 16'hFFFF, 1'b0, 1'b0};
        vecs[11] = '{ASH, 16'hFFFF, 16'h0004, 16'hFFF0, 1'b0, 1'b0};
        vecs[12] = '{ASH, 16'h0003, 16'h0001, 16'h0006, 1'b0, 1'b0};
        vecs[13] = '{ASH, 16'h4000, 16'hFFF0, 16'h0000, 1'b0, 1'b1};
        vecs[14] = '{ROT, 16'h8001, 16'h0001, 16'h0003, 1'b0, 1'b0};
        vecs[15] = '{ROT, 16'h8001, 16'hFFFF, 16'hC000, 1'b0, 1'b0};
        vecs[16] = '{ROT, 16'h8001, 16'h0011, 16'h0003, 1'b0, 1'b0};
        vecs[17] = '{ROT, 16'h8001, 16'h0010, 16'h8001, 1'b0, 1'b0};
        vecs[18] = '{ROT, 16'h1234, 16'hFFFC, 16'h4123, 1'b0, 1'b0};
        vecs[19] = '{ROT, 16'h8001, 16'h8000, 16'h8001, 1'b0, 1'b0};
        vecs[20] = '{LZ,  16'h0000, 16'h0000, 16'h0010, 1'b1, 1'b0};
        vecs[21] = '{LZ,  16'h00FF, 16'h1234, 16'h0008, 1'b0, 1'b0};
        vecs[22] = '{LZ,  16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[23] = '{LO,  16'hFFA0, 16'h0000, 16'h0009, 1'b0, 1'b0};
        vecs[24] = '{LO,  16'h7FFF, 16'h0003, 16'h0000, 1'b0, 1'b1};
        vecs[25] = '{LO,  16'hFFFF, 16'h0000, 16'h0010, 1'b1, 1'b0};
        vecs[26] = '{3'b101, 16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b0};
        vecs[27] = '{3'b111, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};

        rst              = 1'b1;
        vif.ps_shf_en    = 1'b0;
        vif.ps_shf_hold  = 1'b0;
        vif.ps_shf_cls   = 3'b000;
        vif.ps_shf_clr   = 1'b0;
        vif.xb_dtx       = '0;
        vif.xb_dty       = '0;

        // Reset state.
        @(negedge clk);
        chk("rst_dt",  32'(vif.shf_xb_dt),  32'h0);
        chk("rst_vld", 32'(vif.shf_ps_vld), 32'h0);
        chk("rst_sv",  32'(vif.shf_ps_sv),  32'h0);
        chk("rst_sz",  32'(vif.shf_ps_sz),  32'h0);
        chk("rst_svs", 32'(vif.shf_ps_svs), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Table: all vectors issued back-to-back, one per cycle.
        base = n_results;
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].cls, vecs[i].x, vecs[i].y, vecs[i].dt, vecs[i].sv, vecs[i].sz);
            tick();
        end
        idle();
        drain("table");
        chk("table_count", 32'(n_results - base), 32'(NV));
        chk("table_svs", 32'(vif.shf_ps_svs), 32'h1);

        // Clear alone empties the sticky flag.
        vif.ps_shf_clr = 1'b1;
        tick();
        vif.ps_shf_clr = 1'b0;
        @(negedge clk);
        chk("clr_alone", 32'(vif.shf_ps_svs), 32'h0);
        tick();

        // Hold: A, B in flight, hold two edges with a junk issue, then C.
        base = n_results;
        issue(LSH, 16'h00F0, 16'h0004, 16'h0F00, 1'b0, 1'b0);   // A
        tick();
        issue(ROT, 16'h8001, 16'h0001, 16'h0003, 1'b0, 1'b0);   // B
        tick();
        vif.ps_shf_hold = 1'b1;
        drive_op(LZ, 16'h0000, 16'h0000);                      // ignored
        tick();
        @(negedge clk);
        chk("hold1_vld", 32'(vif.shf_ps_vld), 32'h1);
        chk("hold1_dt",  32'(vif.shf_xb_dt),  32'h0F00);
        tick();
        @(negedge clk);
        chk("hold2_vld", 32'(vif.shf_ps_vld), 32'h1);
        chk("hold2_dt",  32'(vif.shf_xb_dt),  32'h0F00);
        vif.ps_shf_hold = 1'b0;
        issue(LO, 16'hFFA0, 16'h0000, 16'h0009, 1'b0, 1'b0);    // C
        tick();
        idle();
        drain("hold");
        chk("hold_count", 32'(n_results - base), 32'h3);
        tick();
        @(negedge clk);
        chk("hold_vld_low", 32'(vif.shf_ps_vld), 32'h0);
        chk("hold_dt_kept", 32'(vif.shf_xb_dt),  32'h0009);
        tick();

        // Sticky: set and clear on the same edge -> set wins.
        issue(ASH, 16'h4000, 16'h0001, 16'h8000, 1'b1, 1'b0);
        tick();
        idle();
        vif.ps_shf_clr = 1'b1;
        tick();
        @(negedge clk);
        chk("svs_set_wins", 32'(vif.shf_ps_svs), 32'h1);
        tick();
        vif.ps_shf_clr = 1'b0;
        @(negedge clk);
        chk("svs_cleared", 32'(vif.shf_ps_svs), 32'h0);
        tick();
        issue(LZ, 16'h0000, 16'h0000, 16'h0010, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("svs_reset_up", 32'(vif.shf_ps_svs), 32'h1);
        tick();
        vif.ps_shf_hold = 1'b1;
        vif.ps_shf_clr  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("svs_hold_clr", 32'(vif.shf_ps_svs), 32'h1);
        vif.ps_shf_hold = 1'b0;
        vif.ps_shf_clr  = 1'b0;
        tick();
        drain("sticky");

        // Async reset mid-stream: outputs drop without a clock edge.
        issue(ASH, 16'h4000, 16'h0001, 16'h8000, 1'b1, 1'b0);
        tick();
        issue(LSH, 16'h00F0, 16'h0004, 16'h0F00, 1'b0, 1'b0);
        tick();
        issue(ROT, 16'h8001, 16'h0001, 16'h0003, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_vld", 32'(vif.shf_ps_vld), 32'h1);
        chk("pre_rst_svs", 32'(vif.shf_ps_svs), 32'h1);
        @(posedge clk);
        #1;
        idle();
        #1;
        rst = 1'b1;
        #1;
        chk("async_vld", 32'(vif.shf_ps_vld), 32'h0);
        chk("async_svs", 32'(vif.shf_ps_svs), 32'h0);
        chk("async_dt",  32'(vif.shf_xb_dt),  32'h0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("post_rst_vld", 32'(vif.shf_ps_vld), 32'h0);
        chk("post_rst_dt",  32'(vif.shf_xb_dt),  32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-register shifter unit.
- Executes logical shift, arithmetic shift, rotate, leading-zero count and leading-one count on DATASIZE-bit operands from the crossbar (xb_dtx = operand, xb_dty = signed shift amount).
- Issued by the program sequencer. Adds a result-valid strobe, a pipeline hold, saturating shift amounts for any width, and a sticky overflow flag.

Parameters:
- DATASIZE, 16, operand/result width; power of two, >= 8.
- CNTW, $clog2(DATASIZE)+1, width of the leading-count result; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ps_shf_en  input  1  issue strobe; captures operands when high and not held
- ps_shf_hold  input  1  freezes both pipeline stages
- ps_shf_cls  input  3  op: 000 LSHIFT, 001 ASHIFT, 010 ROT, 011 LEFTZ, 100 LEFTO, others reserved
- ps_shf_clr  input  1  clears the sticky overflow flag
- xb_dtx  input  DATASIZE  operand
- xb_dty  input  DATASIZE  signed shift amount; ignored for LEFTZ/LEFTO
- shf_xb_dt  output  DATASIZE  result
- shf_ps_vld  output  1  result valid
- shf_ps_sv  output  1  overflow, per result
- shf_ps_sz  output  1  zero, per result
- shf_ps_svs  output  1  sticky overflow

Behaviour:
- Reset (async): shf_xb_dt=0, shf_ps_vld=0, shf_ps_sv=0, shf_ps_sz=0, shf_ps_svs=0, stage-1 valid=0.
  - Reset mid-operation discards all in-flight ops.
- Stage 1 (edge N, hold=0):
  - stage-1 valid <= ps_shf_en.
  - If en=1, latch cls, xb_dtx and xb_dty.
- Stage 2 (edge N+1, hold=0):
  - Compute from the stage-1 registers and register shf_xb_dt, sv and sz.
  - shf_ps_vld <= stage-1 valid.
  - Latency is 2 edges; throughput is one op per cycle.
- Hold=1: both stages, all outputs and shf_ps_svs hold their values; en is ignored. No op is lost or duplicated across a hold.
- Outputs are not cleared when vld drops; they keep the last result.
- Shift amount: s = signed(xb_dty), m = |s| computed at DATASIZE+1 bits so that the most-negative value yields m = 2^(DATASIZE-1).
  - s >= 0 shifts or rotates left; s < 0 shifts or rotates right.
- LSHIFT:
  - m >= DATASIZE: result 0.
  - Left: sv=1 iff any 1 bit is shifted out.
  - Right: zero fill, sv=0.
- ASHIFT:
  - Right: sign fill; m >= DATASIZE gives all sign bits; sv=0.
  - Left: zero fill; m >= DATASIZE gives 0.
  - Left sv=1 iff (result >>> m) != operand, i.e. the value is not representable; m >= DATASIZE with operand != 0 gives sv=1.
- ROT:
  - Rotate by m mod DATASIZE in the direction set by the sign of s; m mod DATASIZE = 0 leaves the operand unchanged.
  - sv=0.
- LEFTZ / LEFTO:
  - Result = count of leading 0s / 1s from the MSB, 0..DATASIZE, zero-extended to DATASIZE.
  - sv=1 iff count == DATASIZE.
- Reserved cls: result 0, sv=0, sz=0.
- sz: 1 iff result == 0 (all non-reserved ops). For LEFTZ/LEFTO this means the MSB differs from the counted bit.
- Sticky shf_ps_svs, evaluated when hold=0:
  - Set when a valid result is registered with sv=1.
  - Else cleared by ps_shf_clr.
  - Set wins over a simultaneous clear.

Test Plan:
- LSHIFT, x=0x00F0, y=0x0004 issued at edge 1 -> edge 3: vld=1, dt=0x0F00, sv=0, sz=0. Next cycle y=0xFFFC -> dt=0x000F. Back-to-back issue gives vld high on consecutive cycles.
- ASHIFT: x=0xF000, y=0xFFFC -> 0xFF00, sv=0. x=0x4000, y=0x0001 -> 0x8000, sv=1, svs=1 from then on. x=0x0001, y=0x0010 -> 0x0000, sz=1, sv=1. x=0x8000, y=0x8000 -> 0xFFFF.
- ROT: x=0x8001 with y=0x0001 -> 0x0003; y=0xFFFF -> 0xC000; y=0x0011 -> 0x0003; y=0x0010 -> 0x8001. sv=0 throughout.
- LEFTZ/LEFTO:
  - LEFTZ x=0x0000 -> 0x0010, sv=1, sz=0; x=0x00FF -> 0x0008.
  - LEFTO x=0xFFA0 -> 0x0009; x=0x7FFF -> 0x0000, sz=1.
  - Reserved cls 101 -> 0x0000, sv=0, sz=0.
- Hold and reset: issue 3 ops and assert hold for 2 cycles after the first edge -> outputs and vld frozen; all 3 results emerge in order with no loss or duplicate. Assert rst mid-stream -> vld=0 and svs=0 immediately, without waiting for a clock edge.
- Sticky: svs=1, then ps_shf_clr asserted on the same edge an sv=1 result registers -> svs stays 1. Clear alone next cycle -> svs=0. Clear while hold=1 -> no effect.
